// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared width and depth constants for the multiplexor and its result FIFO
package mux_pkg;

  localparam int MUX_DATA_W     = 16;
  localparam int MUX_SEL_W      = 3;
  localparam int MUX_FIFO_DEPTH = 4;
  localparam int MUX_PTR_W      = $clog2(MUX_FIFO_DEPTH);

endpackage

// File: rtl/mux_result_ram.sv
// rtl/mux_result_ram.sv - register array with synchronous write and asynchronous read
module mux_result_ram #(
  parameter int W     = 19,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Storage is deliberately not reset; validity is tracked by the FIFO count.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mux_result_fifo.sv
// rtl/mux_result_fifo.sv - captures mux results with their select tag; optional SUM under MUX_RESULT_SUM_EN
module mux_result_fifo
  import mux_pkg::*;
#(
  parameter int DATA_W = MUX_DATA_W,
  parameter int SEL_W  = MUX_SEL_W,
  parameter int DEPTH  = MUX_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      R,
  input  logic [SEL_W-1:0]       SEL,
  input  logic                   en,
  output logic [DATA_W-1:0]      Q,
  output logic [SEL_W-1:0]       Q_SEL,
  output logic                   valid,
  input  logic                   ready,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ovf
`ifdef MUX_RESULT_SUM_EN
  ,
  output logic [DATA_W+7:0]      SUM
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = SEL_W + DATA_W;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_next;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count_next;
  logic [ENT_W-1:0] wr_data;
  logic [ENT_W-1:0] rd_data;
  logic [ENT_W-1:0] head_entry;

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign pop     = valid & ready;
  assign push    = en & ((count != DEPTH_CNT) | pop);
  assign wr_data = {SEL, R};
  assign rd_next = pop ? rd_ptr + PTR_W'(1) : rd_ptr;

  mux_result_ram #(
    .W     (ENT_W),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_next),
    .rdata (rd_data)
  );

  // Next head: bypass the incoming entry when it lands in the slot the head moves to.
  always_comb begin
    head_entry = rd_data;
    if (push && (wr_ptr == rd_next)) begin
      head_entry = wr_data;
    end
  end

  // Occupancy after this edge.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // Pointers, count, registered head and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      empty  <= 1'b1;
      full   <= 1'b0;
      Q      <= '0;
      Q_SEL  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr <= rd_next;
      count  <= count_next;
      valid  <= (count_next != '0);
      empty  <= (count_next == '0);
      full   <= (count_next == DEPTH_CNT);
      {Q_SEL, Q} <= head_entry;
      if (en && !push) begin
        ovf <= 1'b1;
      end
    end
  end

`ifdef MUX_RESULT_SUM_EN
  // Running total of every popped result, wrapping at its own width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      SUM <= '0;
    end else if (pop) begin
      SUM <= SUM + {8'b0, Q};
    end
  end
`endif

endmodule

// File: tb/tb_mux_result_fifo.sv
// tb/tb_mux_result_fifo.sv - directed self-checking bench for mux_result_fifo
module tb_mux_result_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] R = '0;
  logic [2:0]  SEL = '0;
  logic        en = 1'b0;
  logic        ready = 1'b0;
  logic [15:0] Q;
  logic [2:0]  Q_SEL;
  logic        valid;
  logic        full;
  logic        empty;
  logic [2:0]  count;
  logic        ovf;
`ifdef MUX_RESULT_SUM_EN
  logic [23:0] SUM;
`endif

  int checks = 0;
  int errors = 0;

  mux_result_fifo dut (
    .clk   (clk),
    .rst   (rst),
    .R     (R),
    .SEL   (SEL),
    .en    (en),
    .Q     (Q),
    .Q_SEL (Q_SEL),
    .valid (valid),
    .ready (ready),
    .full  (full),
    .empty (empty),
    .count (count),
    .ovf   (ovf)
`ifdef MUX_RESULT_SUM_EN
    ,
    .SUM   (SUM)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " count"}, 32'(count), 32'd0);
    check({tag, " empty"}, 32'(empty), 32'd1);
    check({tag, " full"},  32'(full),  32'd0);
    check({tag, " valid"}, 32'(valid), 32'd0);
    check({tag, " Q"},     32'(Q),     32'd0);
    check({tag, " Q_SEL"}, 32'(Q_SEL), 32'd0);
    check({tag, " ovf"},   32'(ovf),   32'd0);
  endtask

  // Called 1ns after a rising edge: raises rst mid-cycle, checks, releases before the next edge.
  task automatic pulse_rst(input string tag);
    en = 1'b0;
    ready = 1'b0;
    #3 rst = 1'b1;
    #1;
    check_reset_state(tag);
`ifdef MUX_RESULT_SUM_EN
    check({tag, " SUM"}, 32'(SUM), 32'd0);
`endif
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: asynchronous reset before any clock edge
    #3 rst = 1'b1;
    #1;
    check_reset_state("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // 2: single capture, hold, then pop
    SEL = 3'b001; R = 16'h00AB; en = 1'b1; ready = 1'b0;
    tick();
    en = 1'b0; SEL = 3'b000; R = 16'h0000;
    check("single valid", 32'(valid), 32'd1);
    check("single Q", 32'(Q), 32'h00AB);
    check("single Q_SEL", 32'(Q_SEL), 32'd1);
    check("single count", 32'(count), 32'd1);
    tick();
    check("hold Q", 32'(Q), 32'h00AB);
    check("hold valid", 32'(valid), 32'd1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("single drained empty", 32'(empty), 32'd1);
    check("single drained valid", 32'(valid), 32'd0);

    // 3: fill, overflow, drain in order
    for (int i = 1; i <= 5; i++) begin
      R = 16'(i); SEL = 3'(i); en = 1'b1;
      tick();
      if (i == 4) begin
        check("fill full", 32'(full), 32'd1);
        check("fill ovf before drop", 32'(ovf), 32'd0);
      end
    end
    en = 1'b0;
    check("ovf set", 32'(ovf), 32'd1);
    check("ovf count", 32'(count), 32'd4);
    ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain Q", 32'(Q), 32'(i));
      check("drain Q_SEL", 32'(Q_SEL), 32'(i));
      tick();
    end
    ready = 1'b0;
    check("drain empty", 32'(empty), 32'd1);
    check("ovf sticky", 32'(ovf), 32'd1);

    // reset mid-operation with entries stored
    R = 16'h0077; en = 1'b1;
    tick();
    pulse_rst("midreset");

    // 4: full FIFO with simultaneous push and pop
    for (int i = 1; i <= 4; i++) begin
      R = 16'(10 * i); SEL = 3'd2; en = 1'b1;
      tick();
    end
    R = 16'd50; en = 1'b1; ready = 1'b1;
    check("fullpp head", 32'(Q), 32'd10);
    tick();
    en = 1'b0;
    check("fullpp count", 32'(count), 32'd4);
    check("fullpp full", 32'(full), 32'd1);
    check("fullpp ovf", 32'(ovf), 32'd0);
    for (int i = 2; i <= 5; i++) begin
      check("fullpp drain", 32'(Q), 32'(10 * i));
      tick();
    end
    ready = 1'b0;
    check("fullpp empty", 32'(empty), 32'd1);

    // 5: streaming push/pop pairs across pointer wrap
    ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      R = 16'h0100 + 16'(i); en = 1'b1;
      tick();
      check("wrap Q", 32'(Q), 32'h0100 + 32'(i));
      check("wrap count", 32'(count), 32'd1);
    end
    en = 1'b0;
    tick();
    check("wrap empty", 32'(empty), 32'd1);
    // underflow: ready with nothing stored changes nothing
    tick();
    check("underflow count", 32'(count), 32'd0);
    check("underflow ovf", 32'(ovf), 32'd0);
    ready = 1'b0;

`ifdef MUX_RESULT_SUM_EN
    // 6: accumulator over popped results, cleared by reset
    pulse_rst("sumreset");
    R = 16'd170; en = 1'b1; tick();
    R = 16'd1;   tick();
    R = 16'd128; tick();
    R = 16'd192; tick();
    en = 1'b0; ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    ready = 1'b0;
    check("sum total", 32'(SUM), 32'd491);
    R = 16'd5; en = 1'b1;
    tick();
    pulse_rst("sum midreset");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
